// File: rtl/busmux_pkg.sv
// Shared definitions for the register-bus initiator and its bus mux neighbours:
// bus address width, default data width and the initiator state encodings.
package busmux_pkg;

   localparam int unsigned BUS_ADDRW = 8;
   localparam int unsigned DATAW_DEF = 8;
   localparam int unsigned STATEW    = 2;

   localparam logic [STATEW-1:0] ST_IDLE  = 2'd0;
   localparam logic [STATEW-1:0] ST_ISSUE = 2'd1;
   localparam logic [STATEW-1:0] ST_WAIT  = 2'd2;
   localparam logic [STATEW-1:0] ST_RESP  = 2'd3;

   // Latency counter needs at least two bits, more for long responder latencies.
   function automatic int unsigned cnt_width(input int unsigned lat);
      return (lat > 4) ? $clog2(lat) : 2;
   endfunction

endpackage

// File: rtl/regbus_initiator_if.sv
// Host command/response handshake plus register-bus signals of the initiator.
// master = initiator side, slave = host/responder side.
interface regbus_initiator_if
   import busmux_pkg::*;
#(
   parameter int unsigned DATAW = DATAW_DEF
) ();

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_we;
   logic [BUS_ADDRW-1:0] req_addr;
   logic [DATAW-1:0]     req_wdata;

   logic                 bus_we;
   logic [BUS_ADDRW-1:0] bus_addr;
   logic [DATAW-1:0]     bus_wdata;
   logic [DATAW-1:0]     bus_rdata;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_we;
   logic [DATAW-1:0]     rsp_data;
   logic                 rsp_err;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, bus_rdata, rsp_ready,
      output req_ready, bus_we, bus_addr, bus_wdata, rsp_valid, rsp_we, rsp_data, rsp_err
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, bus_rdata, rsp_ready,
      input  req_ready, bus_we, bus_addr, bus_wdata, rsp_valid, rsp_we, rsp_data, rsp_err
   );

endinterface

// File: rtl/regbus_initiator.sv
// Register-bus initiator: one command in, one bus access, one response out.
// Optional REGBUS_READBACK_VERIFY_EN: writes are read back and compared (o_rsp_err).
module regbus_initiator
   import busmux_pkg::*;
#(
   parameter int unsigned DATAW  = DATAW_DEF,
   parameter int unsigned RD_LAT = 1
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   regbus_initiator_if.master   bus
);

   localparam int unsigned CNTW = cnt_width(RD_LAT);

   logic [STATEW-1:0]    state_q,     state_d;
   logic [CNTW-1:0]      cnt_q,       cnt_d;
   logic                 cmd_we_q,    cmd_we_d;
   logic [DATAW-1:0]     cmd_wdata_q, cmd_wdata_d;
   logic                 req_ready_q, req_ready_d;
   logic                 bus_we_q,    bus_we_d;
   logic [BUS_ADDRW-1:0] bus_addr_q,  bus_addr_d;
   logic [DATAW-1:0]     bus_wdata_q, bus_wdata_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_we_q,    rsp_we_d;
   logic [DATAW-1:0]     rsp_data_q,  rsp_data_d;
`ifdef REGBUS_READBACK_VERIFY_EN
   logic                 rsp_err_q,   rsp_err_d;
`endif

   // State, counter, command latch and all registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cmd_we_q    <= 1'b0;
         cmd_wdata_q <= '0;
         req_ready_q <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_data_q  <= '0;
`ifdef REGBUS_READBACK_VERIFY_EN
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_we_q    <= cmd_we_d;
         cmd_wdata_q <= cmd_wdata_d;
         req_ready_q <= req_ready_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_data_q  <= rsp_data_d;
`ifdef REGBUS_READBACK_VERIFY_EN
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   // Next state and next registered outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_we_d    = cmd_we_q;
      cmd_wdata_d = cmd_wdata_q;
      bus_we_d    = 1'b0;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_we_d    = rsp_we_q;
      rsp_data_d  = rsp_data_q;
`ifdef REGBUS_READBACK_VERIFY_EN
      rsp_err_d   = rsp_err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               cmd_we_d    = bus.req_we;
               cmd_wdata_d = bus.req_wdata;
               bus_we_d    = bus.req_we;
               bus_addr_d  = bus.req_addr;
               bus_wdata_d = bus.req_wdata;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            rsp_we_d = cmd_we_q;
            cnt_d    = CNTW'(RD_LAT - 1);
`ifdef REGBUS_READBACK_VERIFY_EN
            state_d  = ST_WAIT;
`else
            if (cmd_we_q) begin
               rsp_data_d  = cmd_wdata_q;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               state_d     = ST_WAIT;
            end
`endif
         end
         ST_WAIT: begin
            // Responder data is valid in the cycle where the counter reaches zero.
            if (cnt_q == '0) begin
               rsp_data_d  = bus.bus_rdata;
`ifdef REGBUS_READBACK_VERIFY_EN
               rsp_err_d   = cmd_we_q && (bus.bus_rdata != cmd_wdata_q);
`endif
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   assign bus.req_ready = req_ready_q;
   assign bus.bus_we    = bus_we_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_wdata = bus_wdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_we    = rsp_we_q;
   assign bus.rsp_data  = rsp_data_q;
`ifdef REGBUS_READBACK_VERIFY_EN
   assign bus.rsp_err   = rsp_err_q;
`else
   assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_regbus_initiator.sv
// Bench for regbus_initiator: four-register slave at RD_LAT=1 plus a second
// instance at RD_LAT=3 fed by a cycle-accurate delayed-data model.
module tb_regbus_initiator;
   import busmux_pkg::*;

   localparam int unsigned DW      = 8;
   localparam int unsigned RD_LAT  = 1;
   localparam int unsigned RD_LAT3 = 3;
`ifdef REGBUS_READBACK_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   regbus_initiator_if #(.DATAW(DW)) bif ();
   regbus_initiator_if #(.DATAW(DW)) bif3 ();

   regbus_initiator #(.DATAW(DW), .RD_LAT(RD_LAT)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bif));
   regbus_initiator #(.DATAW(DW), .RD_LAT(RD_LAT3)) u_dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bif3));

   // Four-register slave, registered read with write forwarding, optional stuck-at-zero data.
   logic [DW-1:0] slv_mem [4];
   logic [DW-1:0] slv_rd;
   logic          force_zero;
   always_ff @(posedge clk) begin
      if (bif.bus_we) slv_mem[bif.bus_addr[1:0]] <= bif.bus_wdata;
      slv_rd <= bif.bus_we ? bif.bus_wdata : slv_mem[bif.bus_addr[1:0]];
   end
   assign bif.bus_rdata = force_zero ? '0 : slv_rd;

   logic [DW-1:0] rd3;
   assign bif3.bus_rdata = rd3;

   logic [DW-1:0] ref_mem [4];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction on the RD_LAT=1 instance; starts and ends at a negedge.
   task automatic do_cmd(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input int hold);
      int            lat;
      int            exp_lat;
      logic [DW-1:0] exp_data;
      logic          exp_err;
      if (we) begin
         exp_lat  = VERIFY ? 2 + RD_LAT : 2;
         exp_data = (VERIFY && force_zero) ? 8'h00 : wdata;
         exp_err  = VERIFY && (exp_data != wdata);
         ref_mem[addr[1:0]] = wdata;
      end else begin
         exp_lat  = 2 + RD_LAT;
         exp_data = ref_mem[addr[1:0]];
         exp_err  = 1'b0;
      end
      bif.req_valid = 1'b1;
      bif.req_we    = we;
      bif.req_addr  = addr;
      bif.req_wdata = wdata;
      lat = 0;
      while (bif.req_ready !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("req_ready_idle", 8'(bif.req_ready), 8'd1);
      @(negedge clk);
      bif.req_valid = 1'b0;
      chk("issue_bus_we", 8'(bif.bus_we), 8'(we));
      chk("issue_bus_addr", bif.bus_addr, addr);
      if (we) chk("issue_bus_wdata", bif.bus_wdata, wdata);
      chk("busy_req_ready", 8'(bif.req_ready), 8'd0);
      lat = 1;
      while (bif.rsp_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
         if (bif.rsp_valid !== 1'b1) chk("wait_bus_we", 8'(bif.bus_we), 8'd0);
      end
      chk("rsp_latency", 8'(lat), 8'(exp_lat));
      chk("rsp_we", 8'(bif.rsp_we), 8'(we));
      chk("rsp_data", bif.rsp_data, exp_data);
      chk("rsp_err", 8'(bif.rsp_err), 8'(exp_err));
      for (int i = 0; i < hold; i++) begin
         bif.req_valid = 1'b1;
         bif.req_addr  = 8'($urandom);
         @(negedge clk);
         chk("hold_rsp_valid", 8'(bif.rsp_valid), 8'd1);
         chk("hold_rsp_data", bif.rsp_data, exp_data);
         chk("hold_req_ready", 8'(bif.req_ready), 8'd0);
      end
      bif.req_valid = 1'b0;
      bif.rsp_ready = 1'b1;
      @(negedge clk);
      bif.rsp_ready = 1'b0;
      chk("rsp_released", 8'(bif.rsp_valid), 8'd0);
      chk("ready_after_rsp", 8'(bif.req_ready), 8'd1);
   endtask

   initial begin
      logic [DW-1:0] v;
      logic [DW-1:0] g;
      int            n;
      force_zero     = 1'b0;
      rd3            = '0;
      bif.req_valid  = 1'b0;
      bif.req_we     = 1'b0;
      bif.req_addr   = '0;
      bif.req_wdata  = '0;
      bif.rsp_ready  = 1'b0;
      bif3.req_valid = 1'b0;
      bif3.req_we    = 1'b0;
      bif3.req_addr  = '0;
      bif3.req_wdata = '0;
      bif3.rsp_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 8'(bif.req_ready), 8'd0);
      chk("rst_bus_we", 8'(bif.bus_we), 8'd0);
      chk("rst_bus_addr", bif.bus_addr, 8'd0);
      chk("rst_bus_wdata", bif.bus_wdata, 8'd0);
      chk("rst_rsp_valid", 8'(bif.rsp_valid), 8'd0);
      chk("rst_rsp_data", bif.rsp_data, 8'd0);
      chk("rst_rsp_err", 8'(bif.rsp_err), 8'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 8'(bif.req_ready), 8'd1);

      // Write then read back one register
      do_cmd(1'b1, 8'd2, 8'hA5, 0);
      do_cmd(1'b0, 8'd2, 8'h00, 0);

      // Fill all four registers, read them back in order
      for (int i = 0; i < 4; i++) do_cmd(1'b1, 8'(i), 8'(8'h11 * (i + 1)), 0);
      for (int i = 0; i < 4; i++) do_cmd(1'b0, 8'(i), 8'h00, 0);

      // Response back-pressure
      do_cmd(1'b0, 8'd3, 8'h00, 5);

      // Reset while waiting on read data
      bif.req_valid = 1'b1;
      bif.req_we    = 1'b0;
      bif.req_addr  = 8'd1;
      @(negedge clk);
      bif.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_bus_we", 8'(bif.bus_we), 8'd0);
      chk("midrst_req_ready", 8'(bif.req_ready), 8'd0);
      chk("midrst_bus_addr", bif.bus_addr, 8'd0);
      chk("midrst_rsp_valid", 8'(bif.rsp_valid), 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("midrst_no_rsp", 8'(bif.rsp_valid), 8'd0);
      end
      do_cmd(1'b0, 8'd1, 8'h00, 0);

      // Readback check (error only observable with readback verification)
      do_cmd(1'b1, 8'd1, 8'h5A, 0);
      force_zero = 1'b1;
      do_cmd(1'b1, 8'd1, 8'h5A, 1);
      force_zero = 1'b0;

      // Randomized command mix against the register model
      for (int i = 0; i < 24; i++)
         do_cmd(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), $urandom_range(0, 2));

      // RD_LAT=3: data must be taken from cycle 4, not earlier or later
      v = 8'($urandom);
      g = v ^ 8'(1 + $urandom_range(0, 254));
      bif3.req_valid = 1'b1;
      bif3.req_we    = 1'b0;
      bif3.req_addr  = 8'h07;
      n = 0;
      while (bif3.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("lat3_req_ready", 8'(bif3.req_ready), 8'd1);
      @(negedge clk);
      bif3.req_valid = 1'b0;
      rd3 = g;
      chk("lat3_bus_addr", bif3.bus_addr, 8'h07);
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         rd3 = (c == 4) ? v : g;
         chk("lat3_not_yet_valid", 8'(bif3.rsp_valid), 8'd0);
      end
      @(negedge clk);
      rd3 = ~v;
      chk("lat3_rsp_valid_c5", 8'(bif3.rsp_valid), 8'd1);
      chk("lat3_rsp_data", bif3.rsp_data, v);
      bif3.rsp_ready = 1'b1;
      @(negedge clk);
      bif3.rsp_ready = 1'b0;
      chk("lat3_released", 8'(bif3.rsp_valid), 8'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
